cnn_cfg_seq: RTL

OBI manager sequencer that programs and runs the CNN accelerator through its register-access subordinate port. On a start pulse it writes the nine kernel weights, input and output base addresses and the CTRL start register, then polls STATUS until the accelerator reports completion. It sits between a host-side trigger (timer, GPIO or core shim) and the accelerator's `sbr_obi` port, so a full layer launch needs no per-register CPU writes.

---
 rtl/cnn_cfg_pkg.sv | 59 +++++
 rtl/cnn_obi_single_mgr.sv | 62 ++++++
 rtl/cnn_cfg_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_cfg_pkg.sv
// Shared types and register map for the CNN configuration sequencer.
// Holds the OBI request/response structs used by the sequencer and its bus port.
package cnn_cfg_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic [1:0]  a_optional;
  } cnn_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    cnn_obi_a_chan_t a;
  } cnn_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } cnn_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    cnn_obi_r_chan_t r;
  } cnn_obi_rsp_t;

  localparam int unsigned NumWeights = 9;
  localparam int unsigned NumWrites  = NumWeights + 3;

  localparam logic [31:0] CtrlOff    = 32'h00;
  localparam logic [31:0] StatusOff  = 32'h04;
  localparam logic [31:0] InBaseOff  = 32'h08;
  localparam logic [31:0] OutBaseOff = 32'h0C;
  localparam logic [31:0] WeightOff  = 32'h10;

  localparam logic [31:0] CtrlStart      = 32'h1;
  localparam logic [31:0] StatusDoneMask = 32'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_POLL_REQ,
    ST_POLL_RSP,
    ST_POLL_GAP,
    ST_DONE
  } cfg_state_e;

endpackage

// File: rtl/cnn_obi_single_mgr.sv
// Single-outstanding OBI manager port. cmd_valid is a launch strobe taken while
// no request is up; cmd_ready flags the bus accepting it (req && gnt).
module cnn_obi_single_mgr
  import cnn_cfg_pkg::*;
#(
  parameter type obi_req_t = cnn_obi_req_t,
  parameter type obi_rsp_t = cnn_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_valid,
  output obi_req_t    obi_req,
  input  obi_rsp_t    obi_rsp
);

  logic        req_q, pend_q, we_q;
  logic [31:0] addr_q, wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (cmd_valid && !req_q) begin
        req_q   <= 1'b1;
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end else if (req_q && obi_rsp.gnt) begin
        req_q <= 1'b0;
      end
      // rvalid only counts while a granted transfer is awaiting its response
      if (req_q && obi_rsp.gnt)             pend_q <= 1'b1;
      else if (pend_q && obi_rsp.rvalid)    pend_q <= 1'b0;
    end
  end

  assign cmd_ready = req_q && obi_rsp.gnt;
  assign rsp_valid = pend_q && obi_rsp.rvalid;
  assign rsp_rdata = obi_rsp.r.rdata;
  assign rsp_err   = obi_rsp.r.err;

  always_comb begin
    obi_req         = '0;
    obi_req.req     = req_q;
    obi_req.a.addr  = addr_q;
    obi_req.a.we    = we_q;
    obi_req.a.be    = '1;
    obi_req.a.wdata = wdata_q;
  end

endmodule

// File: rtl/cnn_cfg_seq.sv
// Programs weights/bases/CTRL into the CNN accelerator over OBI, then polls STATUS.
// Optional bounded polling via CNN_CFG_POLL_TIMEOUT_EN (err after PollTimeout polls).
module cnn_cfg_seq
  import cnn_cfg_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
  parameter type         obi_req_t   = cnn_obi_req_t,
  parameter type         obi_rsp_t   = cnn_obi_rsp_t,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] CnnBaseAddr = 32'h2000_0000,
  parameter int unsigned PollGap     = 4,
  parameter int unsigned PollTimeout = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [NumWeights*DATA_WIDTH-1:0] weights_i,
  input  logic [31:0]                      input_base_i,
  input  logic [31:0]                      output_base_i,
  output obi_req_t                         mgr_obi_req_o,
  input  obi_rsp_t                         mgr_obi_rsp_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int unsigned DW   = ObiCfg.DataWidth;
  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

  typedef logic [NumWeights-1:0][DATA_WIDTH-1:0] wvec_t;

  cfg_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  wvec_t       w_q;
  logic [31:0] in_q, out_q;
  logic        busy_q, done_q, err_q;
  logic        latch, err_set;

  logic        cmd_valid, cmd_we, cmd_ready, rsp_valid, rsp_err;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic        status_done;

`ifdef CNN_CFG_POLL_TIMEOUT_EN
  localparam int unsigned PollCntW = $clog2(PollTimeout + 1);
  logic [PollCntW-1:0] poll_q, poll_d;
`endif

  function automatic logic [DW-1:0] sext(input logic [DATA_WIDTH-1:0] w);
    return {{(DW-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
  endfunction

  function automatic logic [31:0] wr_addr(input logic [3:0] idx);
    if (idx < 4'(NumWeights))        return CnnBaseAddr + WeightOff + {26'd0, idx, 2'b00};
    else if (idx == 4'(NumWeights))   return CnnBaseAddr + InBaseOff;
    else if (idx == 4'(NumWeights+1)) return CnnBaseAddr + OutBaseOff;
    return CnnBaseAddr + CtrlOff;
  endfunction

  function automatic logic [31:0] wr_data(input logic [3:0] idx, input wvec_t w,
                                          input logic [31:0] ib, input logic [31:0] ob);
    if (idx < 4'(NumWeights))        return sext(w[idx]);
    else if (idx == 4'(NumWeights))   return ib;
    else if (idx == 4'(NumWeights+1)) return ob;
    return CtrlStart;
  endfunction

  assign status_done = |(rsp_rdata & StatusDoneMask);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    latch     = 1'b0;
    err_set   = 1'b0;
`ifdef CNN_CFG_POLL_TIMEOUT_EN
    poll_d    = poll_q;
`endif
    case (state_q)
      ST_IDLE: if (start_i) begin
        // first write is launched straight from the ports; the latch lands this edge
        latch     = 1'b1;
        idx_d     = '0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = wr_addr(4'd0);
        cmd_wdata = wr_data(4'd0, weights_i, input_base_i, output_base_i);
        state_d   = ST_REQ;
`ifdef CNN_CFG_POLL_TIMEOUT_EN
        poll_d    = '0;
`endif
      end
      ST_REQ: if (cmd_ready) state_d = ST_RSP;
      ST_RSP: if (rsp_valid) begin
        if (rsp_err) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (idx_q == 4'(NumWrites-1)) begin
          cmd_valid = 1'b1;
          cmd_addr  = CnnBaseAddr + StatusOff;
          state_d   = ST_POLL_REQ;
        end else begin
          idx_d     = idx_q + 4'd1;
          cmd_valid = 1'b1;
          cmd_we    = 1'b1;
          cmd_addr  = wr_addr(idx_d);
          cmd_wdata = wr_data(idx_d, w_q, in_q, out_q);
          state_d   = ST_REQ;
        end
      end
      ST_POLL_REQ: if (cmd_ready) state_d = ST_POLL_RSP;
      ST_POLL_RSP: if (rsp_valid) begin
        if (rsp_err) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (status_done) begin
          state_d = ST_DONE;
        end else begin
`ifdef CNN_CFG_POLL_TIMEOUT_EN
          if (poll_q == PollCntW'(PollTimeout - 1)) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            poll_d  = poll_q + 1'b1;
            gap_d   = '0;
            state_d = ST_POLL_GAP;
          end
`else
          gap_d   = '0;
          state_d = ST_POLL_GAP;
`endif
        end
      end
      ST_POLL_GAP: begin
        if (gap_q == GapW'(PollGap - 1)) begin
          cmd_valid = 1'b1;
          cmd_addr  = CnnBaseAddr + StatusOff;
          state_d   = ST_POLL_REQ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      w_q     <= '0;
      in_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
      if (err_set)    err_q <= 1'b1;
      else if (latch) err_q <= 1'b0;
      if (latch) begin
        w_q   <= weights_i;
        in_q  <= input_base_i;
        out_q <= output_base_i;
      end
    end
  end

`ifdef CNN_CFG_POLL_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) poll_q <= '0;
    else         poll_q <= poll_d;
  end
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  cnn_obi_single_mgr #(
    .obi_req_t (obi_req_t),
    .obi_rsp_t (obi_rsp_t)
  ) u_mgr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_valid (rsp_valid),
    .obi_req   (mgr_obi_req_o),
    .obi_rsp   (mgr_obi_rsp_i)
  );

endmodule
